// File: rtl/pipeline_exec_control_if.sv
// Command and pipeline-control bundle between the debug front end and the execution sequencer.
// Latency: none, this is wiring only.
// Backpressure: the front end holds cmd_valid until it sees cmd_ready high at a rising edge.
interface pipeline_exec_control_if #(
    parameter int CNT_W  = 32,
    parameter int STEP_W = 16
);
    logic              cmd_valid;
    logic [2:0]        cmd;
    logic [STEP_W-1:0] cmd_arg;
    logic              cmd_ready;
    logic              halt_instr;
    logic              pipe_enable;
    logic              pipe_flush;
    logic [1:0]        state;
    logic              halted;
    logic              done;
    logic              cmd_err;
    logic [CNT_W-1:0]  cycle_count;

    // Front end / pipeline side: issues commands and reports retiring HALT instructions
    modport master (
        output cmd_valid, cmd, cmd_arg, halt_instr,
        input  cmd_ready, pipe_enable, pipe_flush, state, halted, done, cmd_err, cycle_count
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd, cmd_arg, halt_instr,
        output cmd_ready, pipe_enable, pipe_flush, state, halted, done, cmd_err, cycle_count
    );
endinterface

// File: rtl/pipeline_exec_control.sv
// Execution sequencer: free-run, N-cycle step, halt and flush control of the 5-stage pipeline.
// Latency: an accepted command changes state/pipe_enable/pipe_flush on the following cycle.
// Backpressure: cmd_ready is high in IDLE and RUN, low while stepping or flushing.
module pipeline_exec_control #(
    parameter int CNT_W        = 32,
    parameter int STEP_W       = 16,
    parameter int FLUSH_CYCLES = 5
) (
    input logic                    clk,
    input logic                    rst_n,
    pipeline_exec_control_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_FLUSH = 2'b11
    } state_t;

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_RUN   = 3'b001;
    localparam logic [2:0] CMD_STEP  = 3'b010;
    localparam logic [2:0] CMD_HALT  = 3'b011;
    localparam logic [2:0] CMD_FLUSH = 3'b100;
    localparam logic [2:0] CMD_CLR   = 3'b101;

    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [FL_W-1:0]   FLUSH_LOAD = FL_W'(FLUSH_CYCLES);
    localparam logic [FL_W-1:0]   FL_ONE     = FL_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              halted_q, halted_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              clr_cnt;
    logic              enable_q;
    logic              flush_q;
    logic              ready_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic              accept;
    logic              halt_seen;

    // A retiring HALT only matters while the pipeline is actually advancing
    assign accept    = bus.cmd_valid & ready_q;
    assign halt_seen = bus.halt_instr & enable_q;

    // Next-state and pulse decode; every target gets its default first
    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        flush_cnt_d = flush_cnt_q;
        halted_d    = halted_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        clr_cnt     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.cmd)
                        CMD_RUN: begin
                            if (halted_q) err_d = 1'b1;
                            else          state_d = S_RUN;
                        end
                        CMD_STEP: begin
                            if (halted_q) begin
                                err_d = 1'b1;
                            end else begin
                                state_d    = S_STEP;
                                // A zero step count still advances the pipe once
                                step_cnt_d = (bus.cmd_arg == '0) ? STEP_ONE : bus.cmd_arg;
                            end
                        end
                        CMD_FLUSH: begin
                            state_d     = S_FLUSH;
                            flush_cnt_d = FLUSH_LOAD;
                        end
                        CMD_CLR:             clr_cnt = 1'b1;
                        CMD_NOP, CMD_HALT:   ;
                        default:             err_d = 1'b1;
                    endcase
                end
            end
            S_RUN: begin
                // Halt wins over any concurrent command so done and err never coincide
                if (halt_seen || (accept && bus.cmd == CMD_HALT)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (halt_seen) halted_d = 1'b1;
                end else if (accept && bus.cmd != CMD_NOP) begin
                    err_d = 1'b1;
                end
            end
            S_STEP: begin
                step_cnt_d = step_cnt_q - STEP_ONE;
                if (halt_seen) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    halted_d = 1'b1;
                end else if (step_cnt_q == STEP_ONE) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_FLUSH: begin
                flush_cnt_d = flush_cnt_q - FL_ONE;
                if (flush_cnt_q == FL_ONE) begin
                    state_d  = S_IDLE;
                    halted_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_cnt_q  <= '0;
            flush_cnt_q <= '0;
            halted_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            enable_q    <= 1'b0;
            flush_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            halted_q    <= halted_d;
            done_q      <= done_d;
            err_q       <= err_d;
            enable_q    <= (state_d == S_RUN) || (state_d == S_STEP);
            flush_q     <= (state_d == S_FLUSH);
            ready_q     <= (state_d == S_IDLE) || (state_d == S_RUN);
        end
    end

    // Saturating count of cycles in which the pipeline advanced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else if (clr_cnt) begin
            cycle_cnt_q <= '0;
        end else if (enable_q && cycle_cnt_q != CNT_MAX) begin
            cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
        end
    end

    assign bus.state       = state_q;
    assign bus.cmd_ready   = ready_q;
    assign bus.pipe_enable = enable_q;
    assign bus.pipe_flush  = flush_q;
    assign bus.halted      = halted_q;
    assign bus.done        = done_q;
    assign bus.cmd_err     = err_q;
    assign bus.cycle_count = cycle_cnt_q;

endmodule
